// File: rtl/gpr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wr_arbiter
//
// Owns the single GPR-file write port in the write-back stage. The port is
// shared between the pipeline write-back path (WB pipeline register) and the
// long-latency multiply/divide unit (MDU). One MDU result can be parked in a
// holding register. WB normally has priority. A parked result that keeps
// losing is eventually force-written with a one-cycle pipeline stall.
//
// A busy scoreboard records registers whose value is still owed by the MDU.
// Decode source reads (RAW) and new MDU destinations (WAW) that hit a busy
// register raise stall.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable_CPU          global pipeline advance enable
//   wb_we/addr/data     WB stage write request
//   mdu_issue(_addr)    MDU op launched this cycle, and its destination
//   mdu_valid/addr/data MDU result offered to the arbiter
//   mdu_ready           arbiter can accept an MDU result this cycle
//   rs/rt_addr, _used   decode source registers and their use flags
//   gpr_we/waddr/wdata  GPR file write port
//   stall               freeze pipeline (hazard or forced MDU write)
//   busy_map            scoreboard, bit n set = register n awaits MDU result
// -----------------------------------------------------------------------------
module gpr_wr_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_CPU,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mdu_issue,
  input  logic [ADDR_W-1:0]        mdu_issue_addr,
  input  logic                     mdu_valid,
  input  logic [ADDR_W-1:0]        mdu_addr,
  input  logic [DATA_W-1:0]        mdu_data,
  output logic                     mdu_ready,
  input  logic [ADDR_W-1:0]        rs_addr,
  input  logic [ADDR_W-1:0]        rt_addr,
  input  logic                     rs_used,
  input  logic                     rt_used,
  output logic                     gpr_we,
  output logic [ADDR_W-1:0]        gpr_waddr,
  output logic [DATA_W-1:0]        gpr_wdata,
  output logic                     stall,
  output logic [(1<<ADDR_W)-1:0]   busy_map
);

  localparam int NREG = 1 << ADDR_W;

  // Denial count at which the next denial escalates to a forced write.
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } state_e;

  // One-hot decode of a register address into a scoreboard mask.
  function automatic logic [NREG-1:0] addr_mask(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] m;
    m    = {NREG{1'b0}};
    m[a] = 1'b1;
    return m;
  endfunction

  // Registered state
  state_e             state_q,      state_d;
  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic               hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0]  hold_addr_q,  hold_addr_d;
  logic [DATA_W-1:0]  hold_data_q,  hold_data_d;
  logic [NREG-1:0]    busy_q,       busy_d;

  // Combinational decisions
  logic wb_win;
  logic hold_win;
  logic capture;
  logic hazard;

  // Port grant: WB has priority except during a forced MDU write.
  always_comb begin
    mdu_ready = ~hold_valid_q;
    capture   = mdu_valid & ~hold_valid_q;
    wb_win    = enable_CPU & wb_we & (wb_addr != {ADDR_W{1'b0}}) &
                (state_q != ST_FORCE);
    // Hold is serviced whenever WB does not take the port, including while
    // the pipeline is frozen (enable_CPU low).
    hold_win  = hold_valid_q & ~wb_win;
  end

  // Write-port mux; a granted hold entry for register 0 is consumed silently.
  always_comb begin
    gpr_we    = 1'b0;
    gpr_waddr = {ADDR_W{1'b0}};
    gpr_wdata = {DATA_W{1'b0}};
    if (wb_win) begin
      gpr_we    = 1'b1;
      gpr_waddr = wb_addr;
      gpr_wdata = wb_data;
    end else if (hold_win && (hold_addr_q != {ADDR_W{1'b0}})) begin
      gpr_we    = 1'b1;
      gpr_waddr = hold_addr_q;
      gpr_wdata = hold_data_q;
    end else begin
      gpr_we    = 1'b0;
    end
  end

  // Holding register next-state: capture and drain never coincide because
  // capture requires the slot to be empty.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    if (capture) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = mdu_addr;
      hold_data_d  = mdu_data;
    end else if (hold_win) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Starvation FSM next-state and denial counter.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d      = ST_HOLD;
          starve_cnt_d = 4'd0;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_win) begin
          state_d      = ST_IDLE;
          starve_cnt_d = 4'd0;
        end else if (enable_CPU) begin
          // Denied by WB this cycle.
          if (starve_cnt_q == STARVE_LAST) begin
            state_d      = ST_FORCE;
          end else begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else begin
          // Counter freezes while the pipeline is held.
          starve_cnt_d = starve_cnt_q;
        end
      end
      ST_FORCE: begin
        // WB is locked out, so the hold entry is always written here.
        state_d      = ST_IDLE;
        starve_cnt_d = 4'd0;
      end
      default: begin
        state_d      = ST_IDLE;
        starve_cnt_d = 4'd0;
      end
    endcase
  end

  // Scoreboard next-state: clear on hold grant, then set on issue so that a
  // same-address set/clear leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (hold_win) begin
      busy_d = busy_d & ~addr_mask(hold_addr_q);
    end else begin
      busy_d = busy_d;
    end
    if (enable_CPU && mdu_issue && (mdu_issue_addr != {ADDR_W{1'b0}})) begin
      busy_d = busy_d | addr_mask(mdu_issue_addr);
    end else begin
      busy_d = busy_d;
    end
  end

  // Hazard detection against the registered scoreboard and stall output.
  always_comb begin
    hazard   = (rs_used   & busy_q[rs_addr]) |
               (rt_used   & busy_q[rt_addr]) |
               (mdu_issue & busy_q[mdu_issue_addr]);
    stall    = hazard | (state_q == ST_FORCE);
    busy_map = busy_q;
  end

  // State registers; reset discards any held result and the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= {ADDR_W{1'b0}};
      hold_data_q  <= {DATA_W{1'b0}};
      busy_q       <= {NREG{1'b0}};
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Testbench for gpr_wr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the write-port rules.
module tb_gpr_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SM = 4;
  localparam int NR = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          enable_CPU, wb_we, mdu_issue, mdu_valid, rs_used, rt_used;
  logic [AW-1:0] wb_addr, mdu_issue_addr, mdu_addr, rs_addr, rt_addr;
  logic [DW-1:0] wb_data, mdu_data;
  logic          mdu_ready, gpr_we, stall;
  logic [AW-1:0] gpr_waddr;
  logic [DW-1:0] gpr_wdata;
  logic [NR-1:0] busy_map;

  gpr_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .enable_CPU(enable_CPU),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .stall(stall), .busy_map(busy_map)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a parked result, how many times it has been refused,
  // whether the next cycle is a forced write, and which registers are owed.
  bit            m_held;
  logic [AW-1:0] m_held_addr;
  logic [DW-1:0] m_held_data;
  int            m_refusals;
  bit            m_forced;
  bit            m_owed [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_held_addr = '0; m_held_data = '0;
    m_refusals = 0; m_forced = 1'b0;
    for (int i = 0; i < NR; i++) m_owed[i] = 1'b0;
  endtask

  function automatic bit wb_takes_port();
    return enable_CPU && wb_we && (wb_addr != 0) && !m_forced;
  endfunction

  // Compare every output with what the model predicts for the current inputs.
  task automatic check_all();
    logic          e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    logic          e_stall;
    logic [NR-1:0] e_map;
    e_we = 1'b0; e_a = '0; e_d = '0;
    if (wb_takes_port()) begin
      e_we = 1'b1; e_a = wb_addr; e_d = wb_data;
    end else if (m_held && m_held_addr != 0) begin
      e_we = 1'b1; e_a = m_held_addr; e_d = m_held_data;
    end
    e_stall = m_forced || (rs_used && m_owed[rs_addr]) ||
              (rt_used && m_owed[rt_addr]) || (mdu_issue && m_owed[mdu_issue_addr]);
    for (int i = 0; i < NR; i++) e_map[i] = m_owed[i];
    chk("gpr_we",    64'(gpr_we),    64'(e_we));
    chk("gpr_waddr", 64'(gpr_waddr), 64'(e_a));
    chk("gpr_wdata", 64'(gpr_wdata), 64'(e_d));
    chk("mdu_ready", 64'(mdu_ready), 64'(!m_held));
    chk("stall",     64'(stall),     64'(e_stall));
    chk("busy_map",  64'(busy_map),  64'(e_map));
  endtask

  // Advance the model across one clock edge using the inputs held at that edge.
  task automatic model_edge();
    bit had;
    had = m_held;
    if (had && !wb_takes_port()) begin
      m_owed[m_held_addr] = 1'b0;
      m_held = 1'b0; m_refusals = 0; m_forced = 1'b0;
    end else if (had) begin
      m_refusals++;
      if (m_refusals == SM) m_forced = 1'b1;
    end
    if (enable_CPU && mdu_issue && mdu_issue_addr != 0) m_owed[mdu_issue_addr] = 1'b1;
    if (mdu_valid && !had) begin
      m_held = 1'b1; m_held_addr = mdu_addr; m_held_data = mdu_data; m_refusals = 0;
    end
  endtask

  task automatic settle();
    #4;
    check_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    enable_CPU = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_issue = 1'b0; mdu_issue_addr = '0; mdu_valid = 1'b0; mdu_addr = '0;
    mdu_data = '0; rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(mdu_ready), 64'd1);
    chk("rst_we",    64'(gpr_we),    64'd0);
    chk("rst_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst_wdata", 64'(gpr_wdata), 64'd0);
    chk("rst_stall", 64'(stall),     64'd0);
    chk("rst_busy",  64'(busy_map),  64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Idle port: MDU result to r7 is written the cycle after capture.
    mdu_issue = 1'b1; mdu_issue_addr = 5'd7; settle(); edge_step(); mdu_issue = 1'b0;
    settle(); chk("busy7_set", 64'(busy_map[7]), 64'd1);
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'hDEAD_BEEF;
    settle(); edge_step(); mdu_valid = 1'b0;
    settle();
    chk("idle_we",    64'(gpr_we),    64'd1);
    chk("idle_waddr", 64'(gpr_waddr), 64'd7);
    chk("idle_wdata", 64'(gpr_wdata), 64'hDEAD_BEEF);
    chk("idle_ready", 64'(mdu_ready), 64'd0);
    edge_step();
    settle();
    chk("busy7_clr",  64'(busy_map[7]), 64'd0);
    chk("idle_ready2", 64'(mdu_ready), 64'd1);
    edge_step();

    // Starvation: four WB grants, one forced write of r3, then WB again.
    mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h3333_0003;
    settle(); edge_step(); mdu_valid = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h9999_0009;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("starve_we",    64'(gpr_we),    64'd1);
      chk("starve_waddr", 64'(gpr_waddr), (i == 4) ? 64'd3 : 64'd9);
      chk("starve_stall", 64'(stall),     (i == 4) ? 64'd1 : 64'd0);
      edge_step();
    end
    wb_we = 1'b0;

    // RAW hazard on r5; rt reading r6 is clean.
    mdu_issue = 1'b1; mdu_issue_addr = 5'd5; settle(); edge_step(); mdu_issue = 1'b0;
    rs_used = 1'b1; rs_addr = 5'd5; rt_used = 1'b1; rt_addr = 5'd6;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("raw_stall", 64'(stall), 64'd1); edge_step();
    end
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h5555_AAAA;
    settle(); edge_step(); mdu_valid = 1'b0;
    settle();
    chk("raw_we",       64'(gpr_we),    64'd1);
    chk("raw_waddr",    64'(gpr_waddr), 64'd5);
    chk("raw_stall_wr", 64'(stall),     64'd1);
    edge_step();
    settle(); chk("raw_release", 64'(stall), 64'd0); edge_step();
    rs_used = 1'b0;
    settle(); chk("rt_only", 64'(stall), 64'd0); edge_step();
    rt_used = 1'b0;

    // Register 0: never written, hold frees in one cycle, never busy.
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0BAD_0000;
    mdu_issue = 1'b1; mdu_issue_addr = 5'd0;
    settle(); chk("r0_wb_we", 64'(gpr_we), 64'd0); edge_step();
    wb_we = 1'b0; mdu_issue = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h0BAD_0001;
    settle(); edge_step(); mdu_valid = 1'b0;
    settle();
    chk("r0_hold_we", 64'(gpr_we),    64'd0);
    chk("r0_ready",   64'(mdu_ready), 64'd0);
    edge_step();
    settle();
    chk("r0_freed", 64'(mdu_ready),   64'd1);
    chk("r0_busy",  64'(busy_map[0]), 64'd0);
    edge_step();

    // Set/clear collision on r4: new issue wins over the hold write clear.
    mdu_issue = 1'b1; mdu_issue_addr = 5'd4; settle(); edge_step(); mdu_issue = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd4; mdu_data = 32'h4444_4444;
    settle(); edge_step(); mdu_valid = 1'b0;
    mdu_issue = 1'b1; mdu_issue_addr = 5'd4;
    settle();
    chk("coll_waddr", 64'(gpr_waddr), 64'd4);
    chk("coll_stall", 64'(stall),     64'd1);
    edge_step(); mdu_issue = 1'b0;
    settle(); chk("coll_busy4", 64'(busy_map[4]), 64'd1); edge_step();

    // Reset while a result is held and registers are owed.
    mdu_issue = 1'b1; mdu_issue_addr = 5'd10; settle(); edge_step(); mdu_issue = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'h1010_1010;
    settle(); edge_step(); mdu_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(mdu_ready), 64'd1);
    chk("mrst_we",    64'(gpr_we),    64'd0);
    chk("mrst_stall", 64'(stall),     64'd0);
    chk("mrst_busy",  64'(busy_map),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    settle(); chk("mrst_nowrite", 64'(gpr_we), 64'd0); edge_step();

    // Random traffic on a narrow register range to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      enable_CPU     = ($urandom_range(0, 9) != 0);
      wb_we          = ($urandom_range(0, 3) != 0);
      wb_addr        = 5'($urandom_range(0, 11));
      wb_data        = $urandom;
      mdu_issue      = ($urandom_range(0, 3) == 0);
      mdu_issue_addr = 5'($urandom_range(0, 11));
      mdu_valid      = ($urandom_range(0, 2) == 0);
      mdu_addr       = 5'($urandom_range(0, 11));
      mdu_data       = $urandom;
      rs_used        = 1'($urandom_range(0, 1));
      rt_used        = 1'($urandom_range(0, 1));
      rs_addr        = 5'($urandom_range(0, 11));
      rt_addr        = 5'($urandom_range(0, 11));
      settle();
      edge_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_wr_arbiter.md
# gpr_wr_arbiter

Controller for the single general-purpose-register-file write port in the write-back stage. Shares the port between the pipeline write-back path (fed from the WB pipeline register) and the long-latency multiply/divide unit (MDU). Tracks MDU destination registers in a busy scoreboard and raises pipeline stalls for RAW/WAW hazards and for MDU starvation. Sits between the WB stage, the MDU result interface, decode, and the GPR file.

## Interface
- DATA_W, 32: GPR data width
- ADDR_W, 5: GPR address width (2^ADDR_W registers; register 0 is hard-wired zero)
- STARVE_MAX, 4: cycles a held MDU result may be denied before the port is force-stolen (1..15)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_CPU  in  1  global pipeline advance enable
- wb_we  in  1  WB stage write request
- wb_addr  in  ADDR_W  WB destination
- wb_data  in  DATA_W  WB write-back data
- mdu_issue  in  1  MDU operation launched this cycle (qualified by enable_CPU)
- mdu_issue_addr  in  ADDR_W  destination of launched MDU op
- mdu_valid  in  1  MDU result available
- mdu_addr  in  ADDR_W  MDU result destination
- mdu_data  in  DATA_W  MDU result
- mdu_ready  out  1  arbiter accepts MDU result this cycle
- rs_addr, rt_addr  in  ADDR_W  decode source registers
- rs_used, rt_used  in  1  source actually read by decoded instruction
- gpr_we  out  1  GPR write enable
- gpr_waddr  out  ADDR_W  GPR write address
- gpr_wdata  out  DATA_W  GPR write data
- stall  out  1  freeze pipeline (drives enable_CPU source low)
- busy_map  out  2^ADDR_W  scoreboard: bit n set = register n awaits MDU result

## Operation
- Holding register (hold_valid, hold_addr, hold_data) buffers one MDU result. mdu_ready = !hold_valid. Capture on mdu_valid && mdu_ready.
- Grant, combinational from registered state:
  - WB wins if enable_CPU && wb_we && wb_addr != 0 && state != FORCE.
  - Else hold wins if hold_valid (including when enable_CPU low).
  - Else no write. gpr_we/waddr/wdata follow the winner; all zero when idle.
- Writes to register 0 never assert gpr_we; a held result to register 0 is dropped in one cycle without asserting gpr_we.
- State machine (registered):
  - IDLE: hold_valid == 0. Capture -> HOLD.
  - HOLD: hold drained -> IDLE, or -> HOLD if a new result is captured the same cycle (ready is low, so not possible; drain always -> IDLE). Denied: starve_cnt++; when starve_cnt == STARVE_MAX-1 and denied -> FORCE.
  - FORCE: stall = 1, hold granted unconditionally, -> IDLE, starve_cnt cleared.
- starve_cnt (4 bit) clears on every hold grant and freezes while enable_CPU is low.
- Scoreboard:
  - Set busy[mdu_issue_addr] on enable_CPU && mdu_issue && addr != 0.
  - Clear busy[hold_addr] when the hold entry is granted.
  - Same-address set and clear in one cycle: set wins.
- hazard = (rs_used && busy[rs_addr]) || (rt_used && busy[rt_addr]) || (mdu_issue && busy[mdu_issue_addr]).
- stall = hazard || (state == FORCE).

## Timing
- Reset values: mdu_ready=1, gpr_we=0, gpr_waddr=0, gpr_wdata=0, stall=0, busy_map=0, state IDLE, starve_cnt=0, hold invalid.
- WB write: zero-latency pass-through, same cycle as wb_we.
- MDU result: captured at edge N; written no earlier than cycle N+1. Written no later than N+STARVE_MAX+1.
- Busy bit visible the cycle after issue. Bit clears at the edge ending the hold-write cycle, so a hazard on that register releases one cycle after gpr_we for it.
- stall from FORCE lasts exactly one cycle. The WB register is frozen, so the denied WB write retries next cycle.
- Reset mid-operation discards held result and scoreboard; no partial write emitted.

## Test plan
- Reset: assert rst_n=0 mid-HOLD -> all outputs at reset values asynchronously, mdu_ready=1.
- Idle port: mdu_valid with addr 7, data 0xDEADBEEF, no wb_we -> capture at N; gpr_we=1, waddr=7 at N+1; busy[7] cleared after.
- Starvation: hold addr 3, wb_we=1 to addr 9 every cycle, STARVE_MAX=4 -> 4 WB grants, then one FORCE cycle with stall=1 writing addr 3; the WB addr-9 write follows next cycle.
- RAW hazard: mdu_issue addr 5, then rs_used with rs_addr=5 -> stall=1 until the cycle after addr-5 result is written; rt-only use of addr 6 causes no stall.
- Register 0: wb_we to addr 0, and MDU result to addr 0 -> gpr_we never 1; hold frees in one cycle; busy_map[0] stays 0.
- Set/clear collision: hold write to addr 4 same cycle as new mdu_issue addr 4 -> busy[4] remains 1.
